// File: rtl/sm4_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_arbiter
//  Description : Two-requester round-robin front end for one SM4 core, with
//                core sequencing, a cycle timeout and a held response port.
//  Revision    : 1.0
// ============================================================================
module sm4_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [255:0] req_data,
    input  logic [255:0] req_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         core_rst_n,
    output logic         core_en,
    output logic [127:0] core_data,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_ready,
    output logic         busy
);

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic           r_grant;
    logic [7:0]     r_count;
    logic [127:0]   r_job_data;
    logic [127:0]   r_job_key;
    logic [127:0]   r_rsp_data;
    logic           r_rsp_id;
    logic           r_rsp_err;

    logic           w_grant;
    logic           w_accept;

    // Contention goes to the requester that was not served last; a lone
    // requester always wins.
    assign w_grant  = (req_valid == 2'b11) ? ~r_last_grant : ~req_valid[0];
    assign w_accept = !rst && (r_state == S_IDLE) && (req_valid != 2'b00);

    assign req_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = !rst && (r_state != S_IDLE);
    assign rsp_valid  = !rst && (r_state == S_RESP);
    assign core_en    = !rst && (r_state == S_RUN);
    assign core_rst_n = !rst && (r_state != S_START);

    assign core_data = r_job_data;
    assign core_key  = r_job_key;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_count      <= 8'd0;
            r_job_data   <= '0;
            r_job_key    <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant    <= w_grant;
                        r_job_data <= w_grant ? req_data[255:128] : req_data[127:0];
                        r_job_key  <= w_grant ? req_key[255:128]  : req_key[127:0];
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_count <= 8'd0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_count <= r_count + 8'd1;
                    // A result arriving in the final cycle still counts as success.
                    if (core_ready) begin
                        r_rsp_data <= core_out;
                        r_rsp_err  <= 1'b0;
                        r_rsp_id   <= r_grant;
                        r_state    <= S_RESP;
                    end else if (r_count == c_timeout_last) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_rsp_id   <= r_grant;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_rsp_id;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sm4_arbiter.md
SM4_ARBITER -- requirements
Module: sm4_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum RUN-state cycles before a job is aborted; legal range 34..255.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 REQ_VALID  input  2  bit i = requester i has a job pending.
REQ-005 REQ_READY  output  2  bit i = job of requester i is accepted this cycle; one-hot or zero.
REQ-006 REQ_DATA  input  256  plaintext; [127:0] is requester 0, [255:128] is requester 1.
REQ-007 REQ_KEY  input  256  user key; same slicing as REQ_DATA.
REQ-008 RSP_VALID  output  1  result available.
REQ-009 RSP_READY  input  1  consumer accepts the result.
REQ-010 RSP_ID  output  1  requester index that owns the result.
REQ-011 RSP_DATA  output  128  ciphertext, or zero on error.
REQ-012 RSP_ERR  output  1  the job timed out.
REQ-013 CORE_RST_N  output  1  active-low restart to the SM4 core.
REQ-014 CORE_EN  output  1  SM4 core enable.
REQ-015 CORE_DATA  output  128  plaintext to the core.
REQ-016 CORE_KEY  output  128  key to the core.
REQ-017 CORE_OUT  input  128  core result.
REQ-018 CORE_READY  input  1  core result valid.
REQ-019 BUSY  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, START, RUN and RESP; no other state is reachable.
REQ-021 IDLE: when any REQ_VALID bit is set, the block SHALL grant one requester, assert that requester's REQ_READY combinationally in the same cycle, register its data and key, and go to START.
REQ-022 Arbitration SHALL be round-robin: a lone requester wins; if both are valid, the winner is the requester other than last_grant.
REQ-023 last_grant SHALL update only on the RSP handshake.
REQ-024 REQ_READY SHALL be zero in every state other than IDLE.
REQ-025 START lasts 1 cycle: CORE_RST_N=0 and CORE_EN=0, then go to RUN.
REQ-026 RUN: CORE_RST_N=1 and CORE_EN=1; an 8-bit cycle counter cleared on RUN entry increments every cycle.
REQ-027 CORE_DATA and CORE_KEY SHALL drive the registered job continuously from START through RESP and hold their last value otherwise.
REQ-028 CORE_READY SHALL be sampled only in RUN.
REQ-029 On CORE_READY=1 in RUN, the block SHALL register RSP_DATA=CORE_OUT, RSP_ERR=0 and RSP_ID=grant, then go to RESP.
REQ-030 If the counter equals TIMEOUT_CYCLES-1 with CORE_READY=0, the block SHALL register RSP_DATA=0 and RSP_ERR=1, then go to RESP.
REQ-031 If CORE_READY=1 in the timeout cycle, the block SHALL report success.
REQ-032 RESP: RSP_VALID=1 and CORE_EN=0; RSP_DATA, RSP_ID and RSP_ERR SHALL remain stable until RSP_READY=1, and the block then returns to IDLE.
REQ-033 Latency: the accept cycle is T, START is T+1, RUN begins at T+2, and RSP_VALID rises the cycle after CORE_READY is sampled.
REQ-034 The next accept SHALL occur no earlier than one cycle after the RSP handshake.
REQ-035 Requesters SHALL hold REQ_VALID, REQ_DATA and REQ_KEY stable until REQ_READY; the block does not check this.

Reset
REQ-036 While RST=1 the block SHALL enter IDLE and drive REQ_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_ID=0, RSP_DATA=0, CORE_RST_N=0, CORE_EN=0, CORE_DATA=0, CORE_KEY=0, BUSY=0 and counter=0.
REQ-037 last_grant SHALL reset to 1, so requester 0 wins the first contention.
REQ-038 RST asserted in any state SHALL abort the job with no response.
REQ-039 In IDLE after reset, CORE_RST_N SHALL be 1.

Verification
REQ-040 Requester 0 sends data and key 0123456789abcdeffedcba9876543210 -> RSP_VALID with RSP_DATA=681edf34d206965e86b3e94f536e4246, RSP_ID=0 and RSP_ERR=0.
REQ-041 Both REQ_VALID bits high after reset -> order of service is 0, 1, 0, 1 across four jobs, with REQ_READY one-hot on each accept.
REQ-042 Core model never raises CORE_READY with TIMEOUT_CYCLES=64 -> RSP_VALID exactly 64 RUN cycles after entering RUN, with RSP_ERR=1 and RSP_DATA=0.
REQ-043 RSP_READY held low for 10 cycles -> RSP outputs stay stable, REQ_READY=0 and BUSY=1 throughout; the new request is accepted 1 cycle after the handshake.
REQ-044 RST pulsed during RUN -> next cycle BUSY=0, CORE_EN=0 and RSP_VALID=0; a new job then completes normally.
REQ-045 CORE_READY arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1 -> RSP_ERR=0 and the valid ciphertext is returned.
